clahe_tile_locator: RTL and testbench

Parametrised pixel-coordinate and tile-position generator for the CLAHE pipeline, which replaces the fixed 1280×720 / 4×4 coordinate counter.
- Supports any resolution and tile grid, including sizes not evenly divisible by the grid; the last tile in each row and column absorbs the remainder.
- Tile index and local coordinates come from incremental counters, with no divide or modulo.
- All outputs are registered and aligned with a one-cycle-delayed pixel strobe.
- Emits frame, line and tile boundary markers for the histogram and interpolation stages.

---
 rtl/clahe_pkg.sv | 31 +++
 rtl/clahe_tile_locator_if.sv | 52 +++++
 rtl/clahe_tile_axis_cnt.sv | 86 ++++++++
 rtl/clahe_tile_locator.sv | 217 +++++++++++++++++++++
 tb/tb_clahe_tile_locator.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clahe_pkg.sv
// ============================================================================
// clahe_pkg : shared FSM encoding and geometry helpers for the tile locator
// Rev 1.0
// ============================================================================
`default_nettype none

package clahe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2
    } state_e;

    // Width of a counter that must hold 0..v-1; never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int tile_size(input int total, input int tiles);
        return total / tiles;
    endfunction

    // The final tile absorbs whatever the even split leaves over.
    function automatic int tile_size_last(input int total, input int tiles);
        return total - (tiles - 1) * tile_size(total, tiles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clahe_tile_locator_if.sv
// ============================================================================
// clahe_tile_locator_if : video-timing inputs and tile-position outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface clahe_tile_locator_if import clahe_pkg::*; #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int TILE_H_NUM = 4,
    parameter int TILE_V_NUM = 4
) ();

    localparam int XW  = clog2_min1(WIDTH);
    localparam int YW  = clog2_min1(HEIGHT);
    localparam int TXW = clog2_min1(TILE_H_NUM);
    localparam int TYW = clog2_min1(TILE_V_NUM);
    localparam int LXW = clog2_min1(tile_size_last(WIDTH, TILE_H_NUM));
    localparam int LYW = clog2_min1(tile_size_last(HEIGHT, TILE_V_NUM));

    logic                 in_href;
    logic                 in_vsync;
    logic                 out_valid;
    logic [XW-1:0]        x_cnt;
    logic [YW-1:0]        y_cnt;
    logic [TXW-1:0]       tile_x;
    logic [TYW-1:0]       tile_y;
    logic [TXW+TYW-1:0]   tile_idx;
    logic [LXW-1:0]       local_x;
    logic [LYW-1:0]       local_y;
    logic                 frame_start;
    logic                 frame_end;
    logic                 line_end;
    logic                 tile_last_x;
    logic                 tile_last_y;
    logic                 geom_err;

    modport master (
        output in_href, in_vsync,
        input  out_valid, x_cnt, y_cnt, tile_x, tile_y, tile_idx, local_x, local_y,
               frame_start, frame_end, line_end, tile_last_x, tile_last_y, geom_err
    );

    modport slave (
        input  in_href, in_vsync,
        output out_valid, x_cnt, y_cnt, tile_x, tile_y, tile_idx, local_x, local_y,
               frame_start, frame_end, line_end, tile_last_x, tile_last_y, geom_err
    );

endinterface

`default_nettype wire

// File: rtl/clahe_tile_axis_cnt.sv
// ============================================================================
// clahe_tile_axis_cnt : one-axis position / tile / in-tile counter, no divide
// Rev 1.0
// ============================================================================
`default_nettype none

module clahe_tile_axis_cnt import clahe_pkg::*; #(
    parameter  int SIZE  = 1280,
    parameter  int TILES = 4,
    localparam int PW    = clog2_min1(SIZE),
    localparam int TW    = clog2_min1(TILES),
    localparam int LW    = clog2_min1(tile_size_last(SIZE, TILES))
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          inc,
    input  wire logic          clr,
    output logic [PW-1:0]      pos,
    output logic [TW-1:0]      tile,
    output logic [LW-1:0]      local_pos,
    output logic               last_in_tile,
    output logic               last_overall,
    output logic               saturated
);

    localparam logic [PW-1:0] SIZE_M1  = PW'(SIZE - 1);
    localparam logic [TW-1:0] TILES_M1 = TW'(TILES - 1);
    localparam logic [LW-1:0] TSZ_M1   = LW'(tile_size(SIZE, TILES) - 1);
    localparam logic [LW-1:0] LAST_M1  = LW'(tile_size_last(SIZE, TILES) - 1);

    logic [PW-1:0] pos_q,  pos_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [LW-1:0] loc_q,  loc_d;
    logic          sat_q,  sat_d;

    assign last_in_tile = (loc_q == ((tile_q == TILES_M1) ? LAST_M1 : TSZ_M1));
    assign last_overall = (pos_q == SIZE_M1);

    // sat_q marks that the final position has already been consumed once.
    always_comb begin
        pos_d  = pos_q;
        tile_d = tile_q;
        loc_d  = loc_q;
        sat_d  = sat_q;
        if (clr) begin
            pos_d  = '0;
            tile_d = '0;
            loc_d  = '0;
            sat_d  = 1'b0;
        end else if (inc) begin
            if (last_overall) begin
                sat_d = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
                if (last_in_tile) begin
                    loc_d  = '0;
                    tile_d = tile_q + 1'b1;
                end else begin
                    loc_d = loc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            tile_q <= '0;
            loc_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            tile_q <= tile_d;
            loc_q  <= loc_d;
            sat_q  <= sat_d;
        end
    end

    assign pos       = pos_q;
    assign tile      = tile_q;
    assign local_pos = loc_q;
    assign saturated = sat_q;

endmodule

`default_nettype wire

// File: rtl/clahe_tile_locator.sv
// ============================================================================
// clahe_tile_locator : registered pixel coordinate and CLAHE tile position
// Optional check macro: CLAHE_TILE_LOCATOR_GEOM_CHECK_EN      Rev 1.0
// ============================================================================
`default_nettype none

module clahe_tile_locator import clahe_pkg::*; #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int TILE_H_NUM = 4,
    parameter int TILE_V_NUM = 4
) (
    input  wire logic           pclk,
    input  wire logic           rst_n,
    clahe_tile_locator_if.slave bus
);

    localparam int XW  = clog2_min1(WIDTH);
    localparam int YW  = clog2_min1(HEIGHT);
    localparam int TXW = clog2_min1(TILE_H_NUM);
    localparam int TYW = clog2_min1(TILE_V_NUM);
    localparam int LXW = clog2_min1(tile_size_last(WIDTH, TILE_H_NUM));
    localparam int LYW = clog2_min1(tile_size_last(HEIGHT, TILE_V_NUM));

    logic rst_meta_q, rst_sync_n_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q   <= 1'b0;
            rst_sync_n_q <= 1'b0;
        end else begin
            rst_meta_q   <= 1'b1;
            rst_sync_n_q <= rst_meta_q;
        end
    end

    state_e state_q, state_d;
    logic   vsync_q;
    logic   vs_rise, accept, line_done;

    logic [XW-1:0]  x_pos;
    logic [TXW-1:0] x_tile;
    logic [LXW-1:0] x_loc;
    logic           x_last_tile, x_last, x_sat;
    logic [YW-1:0]  y_pos;
    logic [TYW-1:0] y_tile;
    logic [LYW-1:0] y_loc;
    logic           y_last_tile, y_last, y_sat;

    // vsync_q resets high so a frame already in progress at release is skipped.
    assign vs_rise = bus.in_vsync && !vsync_q;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        line_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    state_d = bus.in_href ? ST_LINE : ST_HBLANK;
                    accept  = bus.in_href;
                end
            end
            ST_LINE: begin
                if (!bus.in_vsync) begin
                    state_d = ST_IDLE;
                end else if (!bus.in_href) begin
                    state_d   = ST_HBLANK;
                    line_done = 1'b1;
                end else begin
                    accept = 1'b1;
                end
            end
            ST_HBLANK: begin
                if (!bus.in_vsync) begin
                    state_d = ST_IDLE;
                end else if (bus.in_href) begin
                    state_d = ST_LINE;
                    accept  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    clahe_tile_axis_cnt #(.SIZE(WIDTH), .TILES(TILE_H_NUM)) u_x_cnt (
        .clk          (pclk),
        .rst_n        (rst_sync_n_q),
        .inc          (accept),
        .clr          (!bus.in_vsync || line_done),
        .pos          (x_pos),
        .tile         (x_tile),
        .local_pos    (x_loc),
        .last_in_tile (x_last_tile),
        .last_overall (x_last),
        .saturated    (x_sat)
    );

    clahe_tile_axis_cnt #(.SIZE(HEIGHT), .TILES(TILE_V_NUM)) u_y_cnt (
        .clk          (pclk),
        .rst_n        (rst_sync_n_q),
        .inc          (line_done),
        .clr          (!bus.in_vsync),
        .pos          (y_pos),
        .tile         (y_tile),
        .local_pos    (y_loc),
        .last_in_tile (y_last_tile),
        .last_overall (y_last),
        .saturated    (y_sat)
    );

    logic           out_valid_q, out_valid_d;
    logic [XW-1:0]  x_cnt_q, x_cnt_d;
    logic [YW-1:0]  y_cnt_q, y_cnt_d;
    logic [TXW-1:0] tile_x_q, tile_x_d;
    logic [TYW-1:0] tile_y_q, tile_y_d;
    logic [LXW-1:0] local_x_q, local_x_d;
    logic [LYW-1:0] local_y_q, local_y_d;
    logic           frame_start_q, frame_start_d;
    logic           frame_end_q, frame_end_d;
    logic           line_end_q, line_end_d;
    logic           tile_last_x_q, tile_last_x_d;
    logic           tile_last_y_q, tile_last_y_d;

    // Coordinates hold between pixels; the markers are single-pixel pulses.
    always_comb begin
        out_valid_d   = accept;
        x_cnt_d       = accept ? x_pos       : x_cnt_q;
        y_cnt_d       = accept ? y_pos       : y_cnt_q;
        tile_x_d      = accept ? x_tile      : tile_x_q;
        tile_y_d      = accept ? y_tile      : tile_y_q;
        local_x_d     = accept ? x_loc       : local_x_q;
        local_y_d     = accept ? y_loc       : local_y_q;
        tile_last_x_d = accept ? x_last_tile : tile_last_x_q;
        tile_last_y_d = accept ? y_last_tile : tile_last_y_q;
        frame_start_d = accept && (x_pos == '0) && (y_pos == '0) && !x_sat && !y_sat;
        line_end_d    = accept && x_last && !x_sat;
        frame_end_d   = line_end_d && y_last && !y_sat;
    end

    always_ff @(posedge pclk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b1;
            out_valid_q   <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            tile_x_q      <= '0;
            tile_y_q      <= '0;
            local_x_q     <= '0;
            local_y_q     <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_end_q    <= 1'b0;
            tile_last_x_q <= 1'b0;
            tile_last_y_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= bus.in_vsync;
            out_valid_q   <= out_valid_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            tile_x_q      <= tile_x_d;
            tile_y_q      <= tile_y_d;
            local_x_q     <= local_x_d;
            local_y_q     <= local_y_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            line_end_q    <= line_end_d;
            tile_last_x_q <= tile_last_x_d;
            tile_last_y_q <= tile_last_y_d;
        end
    end

`ifdef CLAHE_TILE_LOCATOR_GEOM_CHECK_EN
    logic geom_err_q, geom_err_d;
    logic frame_ok, vs_fall, geom_hit;

    // A frame is complete once the last line has ended, or if vsync drops
    // exactly as the final pixel of the last line is still on href.
    always_comb begin
        vs_fall    = !bus.in_vsync && (state_q != ST_IDLE);
        frame_ok   = y_sat || ((state_q == ST_LINE) && y_last && x_sat);
        geom_hit   = (line_done && !x_sat) || (accept && x_sat) || (vs_fall && !frame_ok);
        geom_err_d = (vs_rise ? 1'b0 : geom_err_q) | geom_hit;
    end

    always_ff @(posedge pclk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            geom_err_q <= 1'b0;
        end else begin
            geom_err_q <= geom_err_d;
        end
    end

    assign bus.geom_err = geom_err_q;
`else
    assign bus.geom_err = 1'b0;
`endif

    assign bus.out_valid   = out_valid_q;
    assign bus.x_cnt       = x_cnt_q;
    assign bus.y_cnt       = y_cnt_q;
    assign bus.tile_x      = tile_x_q;
    assign bus.tile_y      = tile_y_q;
    assign bus.tile_idx    = {tile_y_q, tile_x_q};
    assign bus.local_x     = local_x_q;
    assign bus.local_y     = local_y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.line_end    = line_end_q;
    assign bus.tile_last_x = tile_last_x_q;
    assign bus.tile_last_y = tile_last_y_q;

endmodule

`default_nettype wire

// File: tb/tb_clahe_tile_locator.sv
// ============================================================================
// tb_clahe_tile_locator : 10x6/3x2 and default 1280x720/4x4 locator checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clahe_tile_locator;

    localparam int SW  = 10;
    localparam int SH  = 6;
    localparam int STN = 3;
    localparam int SVN = 2;
`ifdef CLAHE_TILE_LOCATOR_GEOM_CHECK_EN
    localparam bit GEOM_ON = 1'b1;
`else
    localparam bit GEOM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] x;
        logic [2:0] y;
        logic [1:0] tx;
        logic [0:0] ty;
        logic [2:0] idx;
        logic [1:0] lx;
        logic [1:0] ly;
        logic       fs;
        logic       fe;
        logic       le;
        logic       tlx;
        logic       tly;
    } sexp_t;

    logic  clk;
    logic  rst_n;
    int    pass_cnt;
    int    total_cnt;
    sexp_t sb[$];

    clahe_tile_locator_if #(.WIDTH(SW), .HEIGHT(SH), .TILE_H_NUM(STN), .TILE_V_NUM(SVN)) s_if ();
    clahe_tile_locator_if b_if ();

    clahe_tile_locator #(.WIDTH(SW), .HEIGHT(SH), .TILE_H_NUM(STN), .TILE_V_NUM(SVN)) u_small (
        .pclk  (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    clahe_tile_locator u_big (
        .pclk  (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tile geometry computed directly with division.
    function automatic sexp_t mk_s(input int x, input int y, input bit fs, input bit fe, input bit le);
        sexp_t e;
        int tw, th, tx, ty, lx, ly, wsz, hsz;
        tw = SW / STN;
        th = SH / SVN;
        tx = x / tw;
        if (tx > STN - 1) tx = STN - 1;
        ty = y / th;
        if (ty > SVN - 1) ty = SVN - 1;
        lx  = x - tx * tw;
        ly  = y - ty * th;
        wsz = (tx == STN - 1) ? SW - (STN - 1) * tw : tw;
        hsz = (ty == SVN - 1) ? SH - (SVN - 1) * th : th;
        e.x   = 4'(x);
        e.y   = 3'(y);
        e.tx  = 2'(tx);
        e.ty  = 1'(ty);
        e.idx = 3'(ty * 4 + tx);
        e.lx  = 2'(lx);
        e.ly  = 2'(ly);
        e.fs  = fs;
        e.fe  = fe;
        e.le  = le;
        e.tlx = (lx == wsz - 1);
        e.tly = (ly == hsz - 1);
        return e;
    endfunction

    // One clock: drive both DUTs, then score any pixel the small DUT emitted.
    task automatic tick(input logic sh, input logic sv, input logic bh, input logic bv);
        sexp_t exp_v, act;
        s_if.in_href  = sh;
        s_if.in_vsync = sv;
        b_if.in_href  = bh;
        b_if.in_vsync = bv;
        @(posedge clk);
        #1;
        if (s_if.out_valid === 1'b1) begin
            total_cnt++;
            act.x   = s_if.x_cnt;
            act.y   = s_if.y_cnt;
            act.tx  = s_if.tile_x;
            act.ty  = s_if.tile_y;
            act.idx = s_if.tile_idx;
            act.lx  = s_if.local_x;
            act.ly  = s_if.local_y;
            act.fs  = s_if.frame_start;
            act.fe  = s_if.frame_end;
            act.le  = s_if.line_end;
            act.tlx = s_if.tile_last_x;
            act.tly = s_if.tile_last_y;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got pixel %h, required no output", act);
            end else begin
                exp_v = sb.pop_front();
                if (act !== exp_v) $display("FAIL sb_pixel: got %h required %h", act, exp_v);
                else pass_cnt++;
            end
        end
    endtask

    task automatic drive_line_s(input int line_idx, input int npix);
        int x, y;
        for (int i = 0; i < npix; i++) begin
            x = (i > SW - 1) ? SW - 1 : i;
            y = (line_idx > SH - 1) ? SH - 1 : line_idx;
            sb.push_back(mk_s(x, y, (i == 0) && (line_idx == 0),
                              (i == SW - 1) && (line_idx == SH - 1), i == SW - 1));
            tick(1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_sb_empty(input string name);
        total_cnt++;
        if (sb.size() != 0) begin
            $display("FAIL %s_drain: %0d pixels outstanding, required 0", name, sb.size());
            sb.delete();
        end else pass_cnt++;
    endtask

    task automatic check_geom(input string name, input logic exp_v);
        total_cnt++;
        if (s_if.geom_err !== exp_v) $display("FAIL %s: geom_err=%b required %b", name, s_if.geom_err, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        total_cnt++;
        if ({s_if.out_valid, s_if.x_cnt, s_if.y_cnt, s_if.tile_idx, s_if.local_x, s_if.local_y,
             s_if.frame_start, s_if.frame_end, s_if.line_end, s_if.tile_last_x,
             s_if.tile_last_y, s_if.geom_err} !== '0)
            $display("FAIL reset_small: outputs x=%0d y=%0d v=%b, required all 0",
                     s_if.x_cnt, s_if.y_cnt, s_if.out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({b_if.out_valid, b_if.x_cnt, b_if.y_cnt, b_if.tile_idx, b_if.local_x, b_if.local_y,
             b_if.frame_start, b_if.frame_end, b_if.line_end, b_if.tile_last_x,
             b_if.tile_last_y, b_if.geom_err} !== '0)
            $display("FAIL reset_big: outputs x=%0d y=%0d v=%b, required all 0",
                     b_if.x_cnt, b_if.y_cnt, b_if.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_clean_frame;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int l = 0; l < SH; l++) drive_line_s(l, SW);
        check_geom("clean_geom_in_frame", 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({s_if.out_valid, s_if.x_cnt, s_if.y_cnt} !== {1'b0, 4'd9, 3'd5})
            $display("FAIL clean_hold: v=%b x=%0d y=%0d required v=0 x=9 y=5",
                     s_if.out_valid, s_if.x_cnt, s_if.y_cnt);
        else pass_cnt++;
        check_geom("clean_geom_after", 1'b0);
        check_sb_empty("clean");
    endtask

    task automatic test_abort;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        drive_line_s(0, SW);
        drive_line_s(1, SW);
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk_s(i, 2, 1'b0, 1'b0, 1'b0));
            tick(1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (s_if.out_valid !== 1'b0) $display("FAIL abort_href_no_vsync: out_valid=%b required 0", s_if.out_valid);
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_geom("abort_geom_set", GEOM_ON);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check_geom("abort_geom_clear", 1'b0);
        sb.push_back(mk_s(0, 0, 1'b1, 1'b0, 1'b0));
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_sb_empty("abort");
    endtask

    task automatic test_long_line;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        drive_line_s(0, SW + 2);
        check_geom("long_geom", GEOM_ON);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_sb_empty("long");
    endtask

    task automatic test_extra_lines;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int l = 0; l <= SH; l++) drive_line_s(l, SW);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_geom("extra_geom", 1'b0);
        check_sb_empty("extra");
    endtask

    task automatic test_default_geom;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        total_cnt++;
        if ({b_if.out_valid, b_if.frame_start, b_if.x_cnt, b_if.y_cnt, b_if.tile_idx} !==
            {1'b1, 1'b1, 11'd0, 10'd0, 4'd0})
            $display("FAIL big_origin: v=%b fs=%b x=%0d y=%0d idx=%0d required 1 1 0 0 0",
                     b_if.out_valid, b_if.frame_start, b_if.x_cnt, b_if.y_cnt, b_if.tile_idx);
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int l = 1; l < 180; l++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end
        for (int x = 0; x <= 320; x++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            if (x == 319) begin
                total_cnt++;
                if ({b_if.tile_idx, b_if.local_x, b_if.tile_last_x} !== {4'd4, 9'd319, 1'b1})
                    $display("FAIL big_319_180: idx=%0d lx=%0d tlx=%b required 4 319 1",
                             b_if.tile_idx, b_if.local_x, b_if.tile_last_x);
                else pass_cnt++;
            end
            if (x == 320) begin
                total_cnt++;
                if ({b_if.x_cnt, b_if.y_cnt, b_if.tile_idx, b_if.local_x, b_if.local_y} !==
                    {11'd320, 10'd180, 4'd5, 9'd0, 8'd0})
                    $display("FAIL big_320_180: x=%0d y=%0d idx=%0d lx=%0d ly=%0d required 320 180 5 0 0",
                             b_if.x_cnt, b_if.y_cnt, b_if.tile_idx, b_if.local_x, b_if.local_y);
                else pass_cnt++;
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int l = 181; l < 719; l++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end
        for (int x = 0; x < 1280; x++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            if (x == 1279) begin
                total_cnt++;
                if ({b_if.x_cnt, b_if.y_cnt, b_if.tile_idx, b_if.local_x, b_if.local_y,
                     b_if.frame_end, b_if.line_end, b_if.tile_last_x, b_if.tile_last_y} !==
                    {11'd1279, 10'd719, 4'd15, 9'd319, 8'd179, 1'b1, 1'b1, 1'b1, 1'b1})
                    $display("FAIL big_last: x=%0d y=%0d idx=%0d lx=%0d ly=%0d fe=%b le=%b required 1279 719 15 319 179 1 1",
                             b_if.x_cnt, b_if.y_cnt, b_if.tile_idx, b_if.local_x, b_if.local_y,
                             b_if.frame_end, b_if.line_end);
                else pass_cnt++;
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk_s(i, 0, i == 0, 1'b0, 1'b0));
            tick(1'b1, 1'b1, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({s_if.out_valid, s_if.x_cnt, s_if.y_cnt, s_if.tile_idx, s_if.local_x, s_if.local_y,
             s_if.frame_start, s_if.line_end, s_if.tile_last_x, s_if.tile_last_y} !== '0)
            $display("FAIL midreset_async: v=%b x=%0d required all 0", s_if.out_valid, s_if.x_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (s_if.out_valid !== 1'b0) $display("FAIL midreset_wait_vsync: out_valid=%b required 0", s_if.out_valid);
        else pass_cnt++;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk_s(0, 0, 1'b1, 1'b0, 1'b0));
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check_sb_empty("midreset");
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        s_if.in_href  = 1'b0;
        s_if.in_vsync = 1'b0;
        b_if.in_href  = 1'b0;
        b_if.in_vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        test_clean_frame();
        test_abort();
        test_long_line();
        test_extra_lines();
        test_default_geom();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
